lsu_riscv: RTL and testbench

LSU_RISCV -- requirements
Module: lsu_riscv

---
 rtl/lsu_riscv.sv | 144 ++++++++++++++
 tb/tb_lsu_riscv.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_riscv.sv
// rtl/lsu_riscv.sv - RISC-V load/store unit bridging core accesses onto a req/gnt/rvalid data bus
// Optional misalignment trap enabled by defining LSU_MISALIGN_TRAP_EN.
module lsu_riscv (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [2:0]  lsu_size_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_data_i,
    output logic        lsu_stall_req_o,
    output logic [31:0] lsu_data_o,
    output logic        lsu_misaligned_o,
    output logic        data_req_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;

    state_t      r_state;
    logic [2:0]  r_size;
    logic [1:0]  r_off;
    logic        r_req;
    logic        r_we;
    logic [3:0]  r_be;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_data;
    logic        r_misaligned;

    logic        w_illegal;
    logic        w_trap;
    logic [1:0]  w_off;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_shifted;
    logic [31:0] w_load;

    assign w_illegal = (lsu_size_i == 3'd3) || (lsu_size_i[2:1] == 2'b11);

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_trap = !w_illegal &&
                    (((lsu_size_i[1:0] == 2'd1) && lsu_addr_i[0]) ||
                     ((lsu_size_i[1:0] == 2'd2) && (lsu_addr_i[1:0] != 2'b00)));
`else
    assign w_trap = 1'b0;
`endif

    // Byte offset ignores address bits below the access size, so untrapped misaligned accesses round down.
    always_comb begin
        w_off   = 2'b00;
        w_be    = 4'b1111;
        w_wdata = lsu_data_i;
        case (lsu_size_i[1:0])
            2'd0: begin
                w_off   = lsu_addr_i[1:0];
                w_be    = 4'b0001 << lsu_addr_i[1:0];
                w_wdata = {4{lsu_data_i[7:0]}};
            end
            2'd1: begin
                w_off   = {lsu_addr_i[1], 1'b0};
                w_be    = 4'b0011 << {lsu_addr_i[1], 1'b0};
                w_wdata = {2{lsu_data_i[15:0]}};
            end
            default: ;
        endcase
    end

    assign w_shifted = data_rdata_i >> {r_off, 3'b000};

    always_comb begin
        case (r_size)
            3'd0:    w_load = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'd1:    w_load = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'd4:    w_load = {24'd0, w_shifted[7:0]};
            3'd5:    w_load = {16'd0, w_shifted[15:0]};
            default: w_load = w_shifted;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_size       <= 3'd0;
            r_off        <= 2'b00;
            r_req        <= 1'b0;
            r_we         <= 1'b0;
            r_be         <= 4'b0000;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            r_data       <= 32'd0;
            r_misaligned <= 1'b0;
        end else begin
            r_misaligned <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (lsu_req_i) begin
                        r_we    <= lsu_we_i;
                        r_size  <= lsu_size_i;
                        r_off   <= w_off;
                        r_addr  <= lsu_addr_i;
                        r_be    <= w_be;
                        r_wdata <= w_wdata;
                        if (w_illegal || w_trap) begin
                            r_data       <= 32'd0;
                            r_misaligned <= w_trap;
                            r_state      <= S_DONE;
                        end else begin
                            r_req   <= 1'b1;
                            r_state <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (data_gnt_i) begin
                        r_req   <= 1'b0;
                        r_state <= r_we ? S_DONE : S_RESP;
                    end
                end
                S_RESP: begin
                    if (data_rvalid_i) begin
                        r_data  <= w_load;
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign lsu_stall_req_o  = lsu_req_i && (r_state != S_DONE);
    assign lsu_data_o       = r_data;
    assign lsu_misaligned_o = r_misaligned;
    assign data_req_o       = r_req;
    assign data_we_o        = r_we;
    assign data_be_o        = r_be;
    assign data_addr_o      = r_addr;
    assign data_wdata_o     = r_wdata;
endmodule

// File: tb/tb_lsu_riscv.sv
// tb/tb_lsu_riscv.sv - self-checking bench for lsu_riscv (directed table, reset corners, random vs model)
// Expectations follow LSU_MISALIGN_TRAP_EN when it is defined.
module tb_lsu_riscv;
    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        lsu_req_i = 1'b0;
    logic        lsu_we_i = 1'b0;
    logic [2:0]  lsu_size_i = 3'd0;
    logic [31:0] lsu_addr_i = 32'd0;
    logic [31:0] lsu_data_i = 32'd0;
    logic        lsu_stall_req_o;
    logic [31:0] lsu_data_o;
    logic        lsu_misaligned_o;
    logic        data_req_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o;
    logic [31:0] data_wdata_o;
    logic        data_gnt_i = 1'b0;
    logic        data_rvalid_i = 1'b0;
    logic [31:0] data_rdata_i = 32'd0;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    lsu_riscv dut (
        .clk_i(clk), .rst_i(rst_i),
        .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_size_i(lsu_size_i),
        .lsu_addr_i(lsu_addr_i), .lsu_data_i(lsu_data_i),
        .lsu_stall_req_o(lsu_stall_req_o), .lsu_data_o(lsu_data_o),
        .lsu_misaligned_o(lsu_misaligned_o),
        .data_req_o(data_req_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
        .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
        .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i)
    );

    typedef struct {
        logic        we;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] rdata;
        int          gw;
        int          rw;
        logic [31:0] e_data;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        int          e_stall;
        int          e_req;
        int          e_mis;
    } vec_t;

    typedef struct {
        int          stall;
        int          reqc;
        int          mis;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] addr;
        logic        we;
        logic [31:0] data;
        bit          unstable;
        bit          timeout;
    } obs_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t model(input vec_t v, input logic [31:0] prev);
        vec_t        m;
        int          sz;
        int          off;
        logic [31:0] val;
        bit          bad;
        bit          trap;
        m    = v;
        sz   = int'(v.size);
        bad  = (sz == 3) || (sz >= 6);
        trap = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        trap = !bad && (((sz % 4) == 1 && (v.addr % 2) != 0) || ((sz % 4) == 2 && (v.addr % 4) != 0));
`endif
        if ((sz % 4) == 0)      off = int'(v.addr % 4);
        else if ((sz % 4) == 1) off = int'((v.addr % 4) / 2) * 2;
        else                    off = 0;
        if ((sz % 4) == 0) begin
            m.e_be    = 4'(1 << off);
            m.e_wdata = 32'(v.data[7:0]) * 32'h01010101;
        end else if ((sz % 4) == 1) begin
            m.e_be    = 4'(3 << off);
            m.e_wdata = 32'(v.data[15:0]) * 32'h00010001;
        end else begin
            m.e_be    = 4'hF;
            m.e_wdata = v.data;
        end
        val = v.rdata >> (off * 8);
        if ((sz % 4) == 0) begin
            val = val & 32'hFF;
            if (sz < 4 && val >= 32'd128) val = val | 32'hFFFFFF00;
        end else if ((sz % 4) == 1) begin
            val = val & 32'hFFFF;
            if (sz < 4 && val >= 32'd32768) val = val | 32'hFFFF0000;
        end
        if (bad || trap) begin
            m.e_stall = 1;
            m.e_req   = 0;
            m.e_mis   = trap ? 1 : 0;
            m.e_data  = 32'd0;
        end else begin
            m.e_req   = v.gw + 1;
            m.e_mis   = 0;
            m.e_stall = v.we ? 2 + v.gw : 3 + v.gw + v.rw;
            m.e_data  = v.we ? prev : val;
        end
        return m;
    endfunction

    // Called at a negedge; plays the core and a memory with the given grant/response delays.
    task automatic run(input vec_t v, output obs_t o);
        int gwait;
        int rwait;
        bit granted;
        bit first;
        bit fin;
        o = '{default: 0};
        gwait = 0; rwait = 0; granted = 0; first = 1; fin = 0;
        lsu_req_i = 1'b1; lsu_we_i = v.we; lsu_size_i = v.size;
        lsu_addr_i = v.addr; lsu_data_i = v.data;
        for (int cyc = 0; cyc < 40 && !fin; cyc++) begin
            #1;
            if (lsu_misaligned_o) o.mis++;
            if (data_req_o) begin
                o.reqc++;
                if (first) begin
                    o.be = data_be_o; o.wdata = data_wdata_o; o.addr = data_addr_o; o.we = data_we_o;
                    first = 0;
                end else if ({o.be, o.wdata, o.addr, o.we} !== {data_be_o, data_wdata_o, data_addr_o, data_we_o}) begin
                    o.unstable = 1;
                end
            end
            if (!lsu_stall_req_o) begin
                o.data = lsu_data_o;
                fin = 1;
            end else begin
                o.stall++;
                data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = $urandom;
                if (data_req_o) begin
                    if (gwait == v.gw) begin data_gnt_i = 1'b1; granted = 1; end
                    else begin gwait++; data_rvalid_i = 1'($urandom); end
                end else if (granted) begin
                    if (rwait == v.rw) begin data_rvalid_i = 1'b1; data_rdata_i = v.rdata; end
                    else begin rwait++; data_gnt_i = 1'($urandom); end
                end else begin
                    data_gnt_i = 1'($urandom); data_rvalid_i = 1'($urandom);
                end
                @(negedge clk);
            end
        end
        o.timeout = !fin;
        lsu_req_i = 1'b0; data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
        @(negedge clk);
        #1;
        if (lsu_misaligned_o) o.mis++;
        @(negedge clk);
    endtask

    task automatic compare(input string tag, input vec_t e, input obs_t o);
        check({tag, " timeout"}, 32'(o.timeout), 32'd0);
        check({tag, " stall_cycles"}, 32'(o.stall), 32'(e.e_stall));
        check({tag, " req_cycles"}, 32'(o.reqc), 32'(e.e_req));
        check({tag, " misaligned_cycles"}, 32'(o.mis), 32'(e.e_mis));
        check({tag, " lsu_data"}, o.data, e.e_data);
        if (e.e_req > 0) begin
            check({tag, " be"}, 32'(o.be), 32'(e.e_be));
            check({tag, " addr"}, o.addr, e.addr);
            check({tag, " we"}, 32'(o.we), 32'(e.we));
            check({tag, " stable"}, 32'(o.unstable), 32'd0);
            if (e.we) check({tag, " wdata"}, o.wdata, e.e_wdata);
        end
    endtask

    initial begin
        vec_t        tbl [13];
        vec_t        v;
        vec_t        e;
        obs_t        o;
        logic [31:0] prev;
        logic [2:0]  sizes [6];

        tbl[0]  = '{1'b0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 4'hF, 32'h0, 3, 1, 0};
        tbl[1]  = '{1'b0, 3'd0, 32'h103, 32'h0, 32'h80123456, 0, 0, 32'hFFFFFF80, 4'h8, 32'h0, 3, 1, 0};
        tbl[2]  = '{1'b0, 3'd4, 32'h103, 32'h0, 32'h80123456, 0, 1, 32'h00000080, 4'h8, 32'h0, 4, 1, 0};
        tbl[3]  = '{1'b1, 3'd1, 32'h102, 32'h1234ABCD, 32'h0, 2, 0, 32'h00000080, 4'hC, 32'hABCDABCD, 4, 3, 0};
        tbl[4]  = '{1'b0, 3'd1, 32'h102, 32'h0, 32'h80010000, 1, 2, 32'hFFFF8001, 4'hC, 32'h0, 6, 2, 0};
        tbl[5]  = '{1'b0, 3'd5, 32'h000, 32'h0, 32'h1234F00D, 0, 0, 32'h0000F00D, 4'h3, 32'h0, 3, 1, 0};
        tbl[6]  = '{1'b1, 3'd0, 32'h201, 32'h000000A5, 32'h0, 0, 0, 32'h0000F00D, 4'h2, 32'hA5A5A5A5, 2, 1, 0};
        tbl[7]  = '{1'b1, 3'd2, 32'h300, 32'hCAFEF00D, 32'h0, 1, 0, 32'h0000F00D, 4'hF, 32'hCAFEF00D, 3, 2, 0};
        tbl[8]  = '{1'b0, 3'd1, 32'h002, 32'h0, 32'h7FFF0000, 0, 0, 32'h00007FFF, 4'hC, 32'h0, 3, 1, 0};
        tbl[9]  = '{1'b0, 3'd3, 32'h010, 32'h0, 32'hFFFFFFFF, 0, 0, 32'h00000000, 4'h0, 32'h0, 1, 0, 0};
        tbl[11] = '{1'b0, 3'd0, 32'h001, 32'h0, 32'h00007F00, 0, 0, 32'h0000007F, 4'h2, 32'h0, 3, 1, 0};
`ifdef LSU_MISALIGN_TRAP_EN
        tbl[10] = '{1'b0, 3'd2, 32'h101, 32'h0, 32'h11223344, 0, 0, 32'h00000000, 4'h0, 32'h0, 1, 0, 1};
        tbl[12] = '{1'b0, 3'd5, 32'h003, 32'h0, 32'hBEEF0000, 0, 0, 32'h00000000, 4'h0, 32'h0, 1, 0, 1};
`else
        tbl[10] = '{1'b0, 3'd2, 32'h101, 32'h0, 32'h11223344, 0, 0, 32'h11223344, 4'hF, 32'h0, 3, 1, 0};
        tbl[12] = '{1'b0, 3'd5, 32'h003, 32'h0, 32'hBEEF0000, 0, 0, 32'h0000BEEF, 4'hC, 32'h0, 3, 1, 0};
`endif
        sizes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3};

        @(negedge clk); @(negedge clk);
        check("reset data_req", 32'(data_req_o), 32'd0);
        check("reset lsu_data", lsu_data_o, 32'd0);
        check("reset misaligned", 32'(lsu_misaligned_o), 32'd0);
        check("reset be", 32'(data_be_o), 32'd0);
        check("reset we", 32'(data_we_o), 32'd0);
        check("reset addr", data_addr_o, 32'd0);
        check("reset wdata", data_wdata_o, 32'd0);
        rst_i = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            run(tbl[i], o);
            compare($sformatf("vec%0d", i), tbl[i], o);
        end

        // Reset while waiting for grant: request must drop immediately.
        lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_size_i = 3'd2; lsu_addr_i = 32'h80; lsu_data_i = 32'h12345678;
        @(negedge clk);
        check("rst_in_req pre data_req", 32'(data_req_o), 32'd1);
        rst_i = 1'b1;
        #1;
        check("rst_in_req data_req", 32'(data_req_o), 32'd0);
        check("rst_in_req be", 32'(data_be_o), 32'd0);
        check("rst_in_req wdata", data_wdata_o, 32'd0);
        check("rst_in_req we", 32'(data_we_o), 32'd0);
        @(negedge clk);
        rst_i = 1'b0; lsu_req_i = 1'b0;
        @(negedge clk);

        // Reset in RESP, then a stale response that must be discarded.
        lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 3'd2; lsu_addr_i = 32'h40;
        @(negedge clk);
        data_gnt_i = 1'b1;
        @(negedge clk);
        data_gnt_i = 1'b0;
        rst_i = 1'b1;
        #1;
        check("rst_in_resp data_req", 32'(data_req_o), 32'd0);
        check("rst_in_resp lsu_data", lsu_data_o, 32'd0);
        check("rst_in_resp addr", data_addr_o, 32'd0);
        @(negedge clk);
        rst_i = 1'b0; lsu_req_i = 1'b0;
        data_rvalid_i = 1'b1; data_rdata_i = 32'h55AA55AA;
        @(negedge clk);
        data_rvalid_i = 1'b0;
        @(negedge clk);
        check("stale_rvalid lsu_data", lsu_data_o, 32'd0);
        check("stale_rvalid data_req", 32'(data_req_o), 32'd0);

        prev = 32'd0;
        for (int i = 0; i < 40; i++) begin
            v = '{default: 0};
            v.we    = 1'($urandom);
            v.size  = sizes[$urandom_range(0, 5)];
            v.addr  = $urandom;
            v.data  = $urandom;
            v.rdata = $urandom;
            v.gw    = int'($urandom_range(0, 2));
            v.rw    = int'($urandom_range(0, 2));
            e = model(v, prev);
            run(v, o);
            compare($sformatf("rnd%0d", i), e, o);
            prev = e.e_data;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
